// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with configurable frame format, parity/framing error
// reporting, false-start rejection and an internal TX->RX loopback path.
module uart_xcvr #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_dv,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_serial,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    input  logic                 i_rx_serial,
    input  logic                 i_loopback,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err
);

    localparam int              CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit              HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    // Parity bit that makes the frame match the configured odd/even rule.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    tx_state_e              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_serial_q, tx_serial_d;
    logic                   tx_done_q, tx_done_d;

    rx_state_e              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [3:0]             rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_dv_q, rx_dv_d;
    logic                   sync1_q, sync2_q;
    logic                   rx_line;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_serial_q <= tx_serial_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // The line value is registered alongside the state so it changes on the same edge.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_serial_d = tx_serial_q;
        tx_done_d   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_serial_d = 1'b1;
                if (i_tx_dv) begin
                    tx_state_d  = TX_START;
                    tx_cnt_d    = '0;
                    tx_bit_d    = '0;
                    tx_shift_d  = i_tx_data;
                    tx_par_d    = parity_of(i_tx_data);
                    tx_serial_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = TX_DATA;
                    tx_serial_d = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (HAS_PARITY) begin
                            tx_state_d  = TX_PARITY;
                            tx_serial_d = tx_par_q;
                        end else begin
                            tx_state_d  = TX_STOP;
                            tx_serial_d = 1'b1;
                        end
                    end else begin
                        tx_bit_d    = tx_bit_q + 1'b1;
                        tx_shift_d  = tx_shift_q >> 1;
                        tx_serial_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = TX_STOP;
                    tx_serial_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign rx_line = i_loopback ? tx_serial_q : i_rx_serial;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_dv_q    <= 1'b0;
        end else begin
            sync1_q    <= rx_line;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    // Start is confirmed at mid-bit; every later sample lands one full bit period on.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_dv_d    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = sync2_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_dv_d    = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = HAS_PARITY && (rx_par_q != parity_of(rx_shift_q));
                    rx_ferr_d  = ~sync2_q;
                    rx_state_d = sync2_q ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign o_tx_serial     = tx_serial_q;
    assign o_tx_busy       = (tx_state_q != TX_IDLE);
    assign o_tx_done       = tx_done_q;
    assign o_rx_dv         = rx_dv_q;
    assign o_rx_data       = rx_data_q;
    assign o_rx_parity_err = rx_perr_q;
    assign o_rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboard bench for uart_xcvr: instance 0 is 8N1, instance 1 is 7E2, both at 10 clocks per bit.
// Expected line waveforms and received words come from a frame model built from the frame rules.
module tb_uart_xcvr;

    localparam int CPB = 10;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [2] = '{1'b0, 1'b0};
    logic       tx_dv     [2] = '{1'b0, 1'b0};
    logic       rx_serial [2] = '{1'b1, 1'b1};
    logic       loopback  [2] = '{1'b0, 1'b0};
    logic [8:0] tx_data   [2] = '{9'd0, 9'd0};
    logic       tx_serial [2];
    logic       tx_busy   [2];
    logic       tx_done   [2];
    logic       rx_dv     [2];
    logic       rx_perr   [2];
    logic       rx_ferr   [2];
    logic [8:0] rx_data   [2];
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;

    assign rx_data[0] = {1'b0, rx_data_a};
    assign rx_data[1] = {2'b00, rx_data_b};

    int n_checks = 0;
    int n_fail   = 0;

    rx_exp_t    rxq0[$], rxq1[$];
    logic [15:0] txq0[$], txq1[$];

    int          busy_run  [2] = '{0, 0};
    logic [15:0] cur_frame [2] = '{16'hFFFF, 16'hFFFF};
    logic        prev_busy [2] = '{1'b0, 1'b0};
    logic        prev_dv   [2] = '{1'b0, 1'b0};
    rx_exp_t     mon_exp;

    uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .i_rst_n(rst_n[0]), .i_tx_dv(tx_dv[0]), .i_tx_data(tx_data[0][7:0]),
        .o_tx_serial(tx_serial[0]), .o_tx_busy(tx_busy[0]), .o_tx_done(tx_done[0]),
        .i_rx_serial(rx_serial[0]), .i_loopback(loopback[0]), .o_rx_dv(rx_dv[0]),
        .o_rx_data(rx_data_a), .o_rx_parity_err(rx_perr[0]), .o_rx_frame_err(rx_ferr[0])
    );

    uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .i_rst_n(rst_n[1]), .i_tx_dv(tx_dv[1]), .i_tx_data(tx_data[1][6:0]),
        .o_tx_serial(tx_serial[1]), .o_tx_busy(tx_busy[1]), .o_tx_done(tx_done[1]),
        .i_rx_serial(rx_serial[1]), .i_loopback(loopback[1]), .o_rx_dv(rx_dv[1]),
        .o_rx_data(rx_data_b), .o_rx_parity_err(rx_perr[1]), .o_rx_frame_err(rx_ferr[1])
    );

    function automatic int dbits(input int s);
        return (s == 0) ? 8 : 7;
    endfunction

    function automatic int pmode(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic int nstops(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    function automatic int flen(input int s);
        return 1 + dbits(s) + ((pmode(s) != 0) ? 1 : 0) + nstops(s);
    endfunction

    function automatic logic [8:0] mask(input int s, input logic [31:0] v);
        return 9'(v & ((32'd1 << dbits(s)) - 32'd1));
    endfunction

    // Line bits of one frame in transmission order; anything past the frame reads as idle high.
    function automatic logic [15:0] build_frame(input int s, input logic [8:0] d,
                                                input bit flip, input bit stopv);
        logic [15:0] f;
        int idx;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        idx  = 1;
        for (int i = 0; i < dbits(s); i++) begin
            f[idx] = d[i];
            idx++;
        end
        if (pmode(s) != 0) begin
            ones   = $countones(d);
            f[idx] = ((pmode(s) == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip;
            idx++;
        end
        f[idx] = stopv;
        return f;
    endfunction

    function automatic void push_rx(input int s, input rx_exp_t e);
        if (s == 0) rxq0.push_back(e);
        else        rxq1.push_back(e);
    endfunction

    function automatic int rx_size(input int s);
        return (s == 0) ? rxq0.size() : rxq1.size();
    endfunction

    function automatic rx_exp_t pop_rx(input int s);
        if (s == 0) return rxq0.pop_front();
        return rxq1.pop_front();
    endfunction

    function automatic void push_tx(input int s, input logic [15:0] f);
        if (s == 0) txq0.push_back(f);
        else        txq1.push_back(f);
    endfunction

    function automatic int tx_size(input int s);
        return (s == 0) ? txq0.size() : txq1.size();
    endfunction

    function automatic logic [15:0] pop_tx(input int s);
        if (s == 0) return txq0.pop_front();
        return txq1.pop_front();
    endfunction

    function automatic void flush(input int s);
        if (s == 0) begin
            rxq0.delete();
            txq0.delete();
        end else begin
            rxq1.delete();
            txq1.delete();
        end
    endfunction

    task automatic checkOutput(input string name, input int s,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (inst %0d): actual=%0h expected=%0h at %0t", name, s, act, exp, $time);
        end
    endtask

    // Issue one transmit strobe; when the request should be taken, queue the line
    // waveform and, in loopback, the word the receiver must report.
    task automatic applyStimulus(input int s, input logic [31:0] d, input bit expect_accept);
        logic [8:0] m;
        m = mask(s, d);
        @(posedge clk); #1;
        tx_data[s] = m;
        tx_dv[s]   = 1'b1;
        if (expect_accept) begin
            push_tx(s, build_frame(s, m, 1'b0, 1'b1));
            if (loopback[s]) push_rx(s, '{data: m, perr: 1'b0, ferr: 1'b0});
        end
        @(posedge clk); #1;
        tx_dv[s] = 1'b0;
    endtask

    // Drive a frame onto the external RX pin, optionally holding the line low afterwards.
    task automatic drive_ext(input int s, input logic [31:0] d, input bit flip,
                             input bit stopv, input int extra_low);
        logic [8:0]  m;
        logic [15:0] f;
        m = mask(s, d);
        f = build_frame(s, m, flip, stopv);
        push_rx(s, '{data: m, perr: (flip && pmode(s) != 0), ferr: !stopv});
        @(posedge clk); #1;
        for (int i = 0; i < flen(s); i++) begin
            rx_serial[s] = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (extra_low > 0) begin
            rx_serial[s] = 1'b0;
            repeat (extra_low * CPB) @(posedge clk);
            #1;
        end
        rx_serial[s] = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int s);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 4000) begin
            @(negedge clk);
            ok = !tx_busy[s] && rx_size(s) == 0 && tx_size(s) == 0;
            n++;
        end
        checkOutput("wait_idle", s, 32'(ok), 32'd1);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input int s);
        checkOutput("rst_tx_serial", s, 32'(tx_serial[s]), 32'd1);
        checkOutput("rst_tx_busy",   s, 32'(tx_busy[s]),   32'd0);
        checkOutput("rst_tx_done",   s, 32'(tx_done[s]),   32'd0);
        checkOutput("rst_rx_dv",     s, 32'(rx_dv[s]),     32'd0);
        checkOutput("rst_rx_data",   s, 32'(rx_data[s]),   32'd0);
        checkOutput("rst_rx_perr",   s, 32'(rx_perr[s]),   32'd0);
        checkOutput("rst_rx_ferr",   s, 32'(rx_ferr[s]),   32'd0);
    endtask

    task automatic reset_inst(input int s);
        @(posedge clk); #1;
        rst_n[s] = 1'b0;
        flush(s);
        @(posedge clk); #1;
        rst_n[s] = 1'b1;
        @(negedge clk);
        check_reset_state(s);
    endtask

    // Monitor: follows each transmitted frame bit by bit against the queued waveform,
    // checks frame length and done/busy handshake, and pops the receive scoreboard on dv.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n[s]) begin
                busy_run[s]  = 0;
                prev_busy[s] = 1'b0;
                prev_dv[s]   = 1'b0;
            end else begin
                if (tx_busy[s]) begin
                    if (busy_run[s] == 0) begin
                        checkOutput("tx_frame_expected", s, 32'(tx_size(s) != 0), 32'd1);
                        cur_frame[s] = (tx_size(s) != 0) ? pop_tx(s) : 16'hFFFF;
                    end
                    checkOutput("tx_line", s, 32'(tx_serial[s]), 32'(cur_frame[s][busy_run[s] / CPB]));
                    busy_run[s]++;
                end
                if (prev_busy[s] && !tx_busy[s])
                    checkOutput("tx_done_at_end", s, 32'(tx_done[s]), 32'd1);
                if (tx_done[s]) begin
                    checkOutput("tx_frame_cycles", s, 32'(busy_run[s]), 32'(flen(s) * CPB));
                    checkOutput("tx_busy_in_done", s, 32'(tx_busy[s]), 32'd0);
                    busy_run[s] = 0;
                end
                if (rx_dv[s]) begin
                    checkOutput("rx_dv_single", s, 32'(prev_dv[s]), 32'd0);
                    checkOutput("rx_dv_expected", s, 32'(rx_size(s) != 0), 32'd1);
                    if (rx_size(s) != 0) begin
                        mon_exp = pop_rx(s);
                        checkOutput("rx_data", s, 32'(rx_data[s]), 32'(mon_exp.data));
                        checkOutput("rx_parity_err", s, 32'(rx_perr[s]), 32'(mon_exp.perr));
                        checkOutput("rx_frame_err", s, 32'(rx_ferr[s]), 32'(mon_exp.ferr));
                    end
                end
                prev_busy[s] = tx_busy[s];
                prev_dv[s]   = rx_dv[s];
            end
        end
    end

    // Absolute time limit so a stuck design still produces a report.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);

        $display("[TB] 8N1 loopback");
        loopback[0] = 1'b1;
        applyStimulus(0, 32'hBE, 1'b1);
        wait_idle(0);

        $display("[TB] 7E2 parity loopback and injected parity error");
        loopback[1] = 1'b1;
        applyStimulus(1, 32'h55, 1'b1);
        wait_idle(1);
        loopback[1] = 1'b0;
        drive_ext(1, 32'h55, 1'b1, 1'b1, 0);
        wait_idle(1);

        $display("[TB] framing error and break");
        loopback[0] = 1'b0;
        drive_ext(0, 32'h5A, 1'b0, 1'b0, 0);
        drive_ext(0, 32'h3C, 1'b0, 1'b0, 3);
        drive_ext(0, 32'hA3, 1'b0, 1'b1, 0);
        wait_idle(0);

        $display("[TB] false start");
        @(posedge clk); #1;
        rx_serial[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_serial[0] = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        drive_ext(0, 32'h69, 1'b0, 1'b1, 0);
        wait_idle(0);

        $display("[TB] busy handshake and back-to-back");
        loopback[0] = 1'b1;
        applyStimulus(0, 32'h12, 1'b1);
        repeat (3 * CPB) @(posedge clk);
        applyStimulus(0, 32'h34, 1'b0);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = tx_done[0];
            n++;
        end
        checkOutput("done_seen", 0, 32'(ok), 32'd1);
        tx_data[0] = 9'h056;
        tx_dv[0]   = 1'b1;
        push_tx(0, build_frame(0, 9'h056, 1'b0, 1'b1));
        push_rx(0, '{data: 9'h056, perr: 1'b0, ferr: 1'b0});
        @(posedge clk); #1;
        tx_dv[0] = 1'b0;
        @(negedge clk);
        checkOutput("b2b_busy", 0, 32'(tx_busy[0]), 32'd1);
        checkOutput("b2b_start_low", 0, 32'(tx_serial[0]), 32'd0);
        wait_idle(0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 32'h9D, 1'b1);
        repeat (4 * CPB) @(posedge clk);
        reset_inst(0);
        applyStimulus(0, 32'hC3, 1'b1);
        wait_idle(0);

        $display("[TB] randomized concurrent traffic");
        loopback[0] = 1'b1;
        loopback[1] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            fork
                applyStimulus(0, $urandom, 1'b1);
                applyStimulus(1, $urandom, 1'b1);
                drive_ext(1, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 0);
            join
            wait_idle(0);
            wait_idle(1);
        end
        loopback[1] = 1'b1;
        for (int r = 0; r < 6; r++) begin
            applyStimulus(1, $urandom, 1'b1);
            wait_idle(1);
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end

        checkOutput("rxq_empty", 0, 32'(rx_size(0)), 32'd0);
        checkOutput("rxq_empty", 1, 32'(rx_size(1)), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: a transmitter and receiver sharing one clock, one frame format and an internal loopback path. It succeeds the fixed 8N1 UART top and adds configurable data width, parity, stop bits and bit period. It also adds parity/framing error reporting, false-start rejection and TX busy/done handshakes. It sits between a byte-level host interface and the serial pins.

## Interface
- CLKS_PER_BIT, 87, clk cycles per serial bit; legal range ≥4.
- DATA_BITS, 8, payload width; legal range 5–9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, transmitted stop bits; legal values 1 or 2.
- clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_tx_dv  in  1  transmit request, one-cycle strobe.
- i_tx_data  in  DATA_BITS  word to send; sampled when i_tx_dv is accepted.
- o_tx_serial  out  1  serial TX line; idles high.
- o_tx_busy  out  1  TX frame in progress.
- o_tx_done  out  1  one-cycle pulse at end of frame.
- i_rx_serial  in  1  serial RX line; asynchronous.
- i_loopback  in  1  1 = RX is fed from internal o_tx_serial instead of i_rx_serial.
- o_rx_dv  out  1  one-cycle pulse when a received word is valid.
- o_rx_data  out  DATA_BITS  last received word; held until next o_rx_dv.
- o_rx_parity_err  out  1  parity mismatch on last word; valid with o_rx_dv and held.
- o_rx_frame_err  out  1  stop bit sampled low on last word; valid with o_rx_dv and held.

## Operation
- Reset (i_rst_n=0 at a clk edge):
  - Both FSMs return to IDLE; bit and cycle counters clear.
  - o_tx_serial=1; o_tx_busy, o_tx_done, o_rx_dv, errors = 0; o_rx_data=0.
  - Synchroniser flops = 1.
  - Reset mid-frame aborts the frame immediately; no done or dv pulse is produced.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - i_tx_dv is accepted only in IDLE; while busy it is ignored, with no queueing.
  - Data bits go out LSB first.
  - Odd parity bit = ~^data; even parity bit = ^data.
  - STOP holds the line high for STOP_BITS bit periods.
- RX path:
  - The selected line passes through a 2-flop synchroniser.
  - IDLE: a synchronised 0 enters START.
  - START: waits CLKS_PER_BIT/2 cycles (integer division), then samples.
    - 1 → false start; return to IDLE with no outputs.
    - 0 → DATA.
  - DATA: samples every CLKS_PER_BIT cycles, DATA_BITS samples, LSB first.
  - PARITY (if enabled): samples one bit and checks it against the configured parity.
  - STOP: samples only the first stop bit.
  - After the stop sample, o_rx_dv pulses and data/errors update, even when an error is flagged.
  - After a framing error (break or misalignment), RX stays in IDLE-wait until the synchronised line reads 1 before arming for the next start.
- Loopback: switching i_loopback mid-frame is not supported. The frame is corrupted but the FSM must recover within one frame time.

## Timing
- Frame length N = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- TX start: with i_tx_dv accepted at edge k, o_tx_serial goes low and o_tx_busy goes high after edge k.
- Each bit holds exactly CLKS_PER_BIT cycles.
- TX end:
  - o_tx_done is high for the single cycle following the last stop-bit cycle.
  - o_tx_busy is low in that same cycle.
  - A new i_tx_dv in that cycle is accepted, giving back-to-back frames with no idle gap.
- RX latency: o_rx_dv asserts on the cycle after the stop-bit mid-sample.
- o_rx_dv is never asserted for more than one consecutive cycle.
- Simultaneous TX and RX activity is fully independent.
- Loopback sample point: the RX start detection lags the TX falling edge by 2 cycles (synchroniser delay).

## Test plan
- **8N1 loopback** (CLKS_PER_BIT=10): send 0xBE → o_rx_dv with o_rx_data=0xBE, both errors 0; o_tx_done exactly 100 cycles after accept.
- **Parity** (DATA_BITS=7, PARITY=2, STOP_BITS=2): loopback 0x55 → parity bit 0 on the line, frame 110 cycles, rx 0x55, no errors. Then drive i_rx_serial externally with the parity bit flipped → o_rx_parity_err=1 with dv, data 0x55.
- **Framing/break**: external frame with stop bit 0 → dv with o_rx_frame_err=1. Hold the line low 3 bit times → no further dv until the line returns high and a valid 0xA3 frame is received cleanly.
- **False start**: 3-cycle low glitch on i_rx_serial → no o_rx_dv; an immediately following valid frame is received correctly.
- **Handshake**: i_tx_dv with 0x12; re-pulse i_tx_dv with 0x34 while busy → ignored. Pulse 0x56 in the done cycle → transmitted back-to-back; RX sees 0x12 then 0x56.
- **Reset mid-frame**: assert i_rst_n=0 during TX DATA and RX DATA → next edge o_tx_serial=1, busy=0, no dv/done. The next frame (0xC3) transmits and receives correctly.
